padctrl_staged: RTL and testbench
=================================

PADCTRL_STAGED -- requirements
Module: padctrl_staged

Interface
REQ-001 SHALL have parameter NMioPads, default 16, number of muxed IO pads.
REQ-002 SHALL have parameter NDioPads, default 4, number of dedicated IO pads.
REQ-003 SHALL have parameter AttrDw, default 8, attribute width per pad (1..32).
REQ-004 SHALL have parameter WarlMask, default 8'h3F, implemented attribute bits.
REQ-005 SHALL have parameter SettleCycles, default 4, hold-off after each pad change (1..255).
REQ-006 SHALL provide clk_i  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL provide rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL provide reg_req_i  input  1  register access strobe.
REQ-009 SHALL provide reg_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL provide reg_addr_i  input  8  word address.
REQ-011 SHALL provide reg_wdata_i  input  32  write data.
REQ-012 SHALL provide reg_ack_o  output  1  access response.
REQ-013 SHALL provide reg_rdata_o  output  32  read data, valid with ack.
REQ-014 SHALL provide reg_err_o  output  1  unmapped-address flag, valid with ack.
REQ-015 SHALL provide mio_attr_o  output  NMioPads*AttrDw  active MIO attributes.
REQ-016 SHALL provide dio_attr_o  output  NDioPads*AttrDw  active DIO attributes.
REQ-017 SHALL provide busy_o  output  1  commit sequence running.
REQ-018 SHALL provide done_o  output  1  one-cycle pulse at sequence end.

Function
REQ-019 Pads indexed p = 0..NP-1, NP = NMioPads+NDioPads; MIO first, then DIO; NP SHALL be <= 64 (elaboration check).
REQ-020 Map: 0x00+p shadow attr (RW); 0x40 COMMIT (W); 0x41 STATUS (R: bit0 busy, bit1 lock, bit2 pending); 0x42 LOCK (W bit0 = 1 sets); 0x80+p active attr (RO).
REQ-021 reg_ack_o SHALL assert exactly one cycle after each reg_req_i cycle; rdata/err registered with it.
REQ-022 Shadow write stores wdata[AttrDw-1:0] & WarlMask; reads return stored value zero-extended.
REQ-023 Unmapped address: write ignored, read returns 0, reg_err_o = 1.
REQ-024 Once locked: shadow, COMMIT and LOCK writes ignored without error; a running sequence completes.
REQ-025 FSM states IDLE, SCAN, SETTLE, DONE.
REQ-026 IDLE: COMMIT write with wdata[0] = 1 -> SCAN at index 0 next cycle; busy_o = 1 from that cycle.
REQ-027 SCAN: shadow[p] == active[p] -> p+1 same state (one cycle per unchanged pad); differs -> copy shadow to active, load counter with SettleCycles, enter SETTLE.
REQ-028 SETTLE: decrement per cycle; at 1 -> SCAN at p+1; last pad exits to DONE instead.
REQ-029 DONE: done_o = 1 for one cycle; -> SCAN at 0 if pending set (pending cleared), else IDLE.
REQ-030 COMMIT during busy SHALL set pending (single-depth, further commits merge).
REQ-031 Shadow writes during a sequence SHALL be honoured for pads not yet scanned.
REQ-032 Outputs SHALL equal active registers, changing only in SCAN, at most one pad per cycle.
REQ-033 Same-cycle COMMIT write and DONE SHALL set pending.

Reset
REQ-034 rst_i asserted SHALL immediately clear shadow, active, lock, pending, counter, index, all outputs to 0; FSM to IDLE.
REQ-035 Reset mid-sequence SHALL abort; no pulse on done_o.

Structure
REQ-036 Address offsets, FSM state enum and default attribute constants SHALL live in package padctrl_staged_pkg.
REQ-037 Register decode/readback SHALL be sub-module padctrl_staged_regs; sequencer stays in top.

Verification
REQ-038 Write 0xFF to 0x03, read 0x03 -> rdata 0x3F, err 0; read 0x83 -> 0x00.
REQ-039 Shadows 0x05 at p2, 0x07 at p19, COMMIT -> p2 output changes, 4 idle cycles, p19 changes; done_o once; busy_o deasserts the cycle after done_o.
REQ-040 COMMIT twice while busy -> STATUS bit2 = 1, exactly one rerun, done_o pulses twice total.
REQ-041 LOCK=1 then write 0x11 to 0x00 and COMMIT -> shadow, outputs unchanged, busy_o stays 0.
REQ-042 Assert rst_i during SETTLE -> all outputs 0 asynchronously, busy_o 0, no done_o.
REQ-043 Read 0x50 -> rdata 0, reg_err_o 1, state unchanged.

Source files
------------

// File: rtl/padctrl_staged_pkg.sv
// padctrl_staged_pkg: shared address map, sequencer states and reset constants for padctrl_staged.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package padctrl_staged_pkg;

  // Word addresses of the register map. The pad windows are 64 words wide,
  // so only the top two address bits select the window.
  localparam logic [7:0] ADDR_SHADOW_BASE = 8'h00;
  localparam logic [7:0] ADDR_COMMIT      = 8'h40;
  localparam logic [7:0] ADDR_STATUS      = 8'h41;
  localparam logic [7:0] ADDR_LOCK        = 8'h42;
  localparam logic [7:0] ADDR_ACTIVE_BASE = 8'h80;

  // Largest pad count the 64-word pad windows can address.
  localparam int MAX_PADS = 64;

  // Value every shadow and active attribute takes out of reset.
  localparam logic [31:0] ATTR_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  // STATUS register payload; first field lands in the highest bit.
  typedef struct packed {
    logic pending;
    logic lock;
    logic busy;
  } status_t;

  function automatic logic [31:0] status_word(input status_t s);
    return {29'd0, s};
  endfunction

endpackage

// File: rtl/padctrl_staged_regs.sv
// padctrl_staged_regs: register decode, shadow attribute storage, lock bit and readback mux.
// Latency: ack, rdata and err are registered one cycle after each reg_req_i cycle.
// Backpressure: none; every strobe is accepted and answered on the following cycle.
// Ports: clk_i/rst_i; reg_* request/response; active_i/busy_i/pending_i for readback;
//        shadow_o/lock_o to the sequencer; commit_o is a same-cycle COMMIT strobe (already lock-qualified).
module padctrl_staged_regs
  import padctrl_staged_pkg::*;
#(
  parameter int                NP       = 20,
  parameter int                AttrDw   = 8,
  parameter int                IdxW     = 5,
  parameter logic [AttrDw-1:0] WarlMask = 'h3F
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         reg_req_i,
  input  logic                         reg_we_i,
  input  logic [7:0]                   reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  input  logic [NP-1:0][AttrDw-1:0]    active_i,
  input  logic                         busy_i,
  input  logic                         pending_i,
  output logic                         reg_ack_o,
  output logic [31:0]                  reg_rdata_o,
  output logic                         reg_err_o,
  output logic [NP-1:0][AttrDw-1:0]    shadow_o,
  output logic                         lock_o,
  output logic                         commit_o
);

  logic [NP-1:0][AttrDw-1:0] shadow_q, shadow_d;
  logic                      lock_q, lock_d;
  logic                      ack_q, err_q, err_d;
  logic [31:0]               rdata_q, rdata_d;

  // Pad offset inside a 64-word window; the extra bit keeps NP = 64 comparable.
  logic [6:0]      pad_off;
  logic            pad_in_range;
  logic [IdxW-1:0] pad_idx;
  logic            hit_shadow, hit_active, hit_commit, hit_status, hit_lock, mapped;
  logic            wr, rd, wr_ok;
  logic            unused_wdata;

  assign pad_off      = {1'b0, reg_addr_i[5:0]};
  assign pad_in_range = pad_off < 7'(NP);
  assign pad_idx      = reg_addr_i[IdxW-1:0];

  assign hit_shadow = (reg_addr_i[7:6] == ADDR_SHADOW_BASE[7:6]) && pad_in_range;
  assign hit_active = (reg_addr_i[7:6] == ADDR_ACTIVE_BASE[7:6]) && pad_in_range;
  assign hit_commit = reg_addr_i == ADDR_COMMIT;
  assign hit_status = reg_addr_i == ADDR_STATUS;
  assign hit_lock   = reg_addr_i == ADDR_LOCK;
  assign mapped     = hit_shadow | hit_active | hit_commit | hit_status | hit_lock;

  assign wr    = reg_req_i & reg_we_i;
  assign rd    = reg_req_i & ~reg_we_i;
  // Once locked, every configuration write is silently dropped (no error).
  assign wr_ok = wr & ~lock_q;

  assign commit_o = wr_ok & hit_commit & reg_wdata_i[0];

  // Only the low AttrDw bits are ever stored.
  assign unused_wdata = ^reg_wdata_i;

  always_comb begin
    shadow_d = shadow_q;
    lock_d   = lock_q;
    rdata_d  = '0;
    err_d    = reg_req_i & ~mapped;

    if (wr_ok && hit_shadow) begin
      shadow_d[pad_idx] = reg_wdata_i[AttrDw-1:0] & WarlMask;
    end
    if (wr_ok && hit_lock && reg_wdata_i[0]) begin
      lock_d = 1'b1;
    end

    // Write-only registers (COMMIT, LOCK) read back as zero without error.
    if (rd) begin
      if (hit_shadow) begin
        rdata_d = 32'(shadow_q[pad_idx]);
      end else if (hit_active) begin
        rdata_d = 32'(active_i[pad_idx]);
      end else if (hit_status) begin
        rdata_d = status_word('{pending: pending_i, lock: lock_q, busy: busy_i});
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= {NP{ATTR_RESET[AttrDw-1:0]}};
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      lock_q   <= lock_d;
      ack_q    <= reg_req_i;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;
  assign reg_err_o   = err_q;
  assign shadow_o    = shadow_q;
  assign lock_o      = lock_q;

endmodule

// File: rtl/padctrl_staged.sv
// padctrl_staged: shadow/active pad attribute bank; COMMIT walks the pads and copies changed shadows to the outputs.
// Latency: register ack 1 cycle after strobe; sequence costs 1 cycle per pad plus SettleCycles per changed pad, plus 1 DONE cycle.
// Backpressure: none; COMMITs arriving while busy collapse into one pending rerun.
// Ports: clk_i, rst_i (async, active-high); reg_req_i/reg_we_i/reg_addr_i/reg_wdata_i -> reg_ack_o/reg_rdata_o/reg_err_o;
//        mio_attr_o/dio_attr_o active attributes, pad 0 in the LSBs; busy_o while sequencing; done_o one-cycle end pulse.
module padctrl_staged
  import padctrl_staged_pkg::*;
#(
  parameter int                NMioPads     = 16,
  parameter int                NDioPads     = 4,
  parameter int                AttrDw       = 8,
  parameter logic [AttrDw-1:0] WarlMask     = 'h3F,
  parameter int                SettleCycles = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         reg_req_i,
  input  logic                         reg_we_i,
  input  logic [7:0]                   reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  output logic                         reg_ack_o,
  output logic [31:0]                  reg_rdata_o,
  output logic                         reg_err_o,
  output logic [NMioPads*AttrDw-1:0]   mio_attr_o,
  output logic [NDioPads*AttrDw-1:0]   dio_attr_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NP   = NMioPads + NDioPads;
  localparam int IdxW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [7:0] SETTLE_LOAD = 8'(SettleCycles);

  if (NP < 1 || NP > MAX_PADS) begin : g_bad_np
    $error("padctrl_staged: NMioPads+NDioPads must be in 1..64");
  end
  if (AttrDw < 1 || AttrDw > 32) begin : g_bad_attrdw
    $error("padctrl_staged: AttrDw must be in 1..32");
  end
  if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle
    $error("padctrl_staged: SettleCycles must be in 1..255");
  end

  seq_state_e                state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      pending_q, pending_d;
  logic [NP-1:0][AttrDw-1:0] active_q, active_d;

  logic [NP-1:0][AttrDw-1:0] shadow;
  logic                      lock;
  logic                      commit;
  logic                      last_pad;

  padctrl_staged_regs #(
    .NP       (NP),
    .AttrDw   (AttrDw),
    .IdxW     (IdxW),
    .WarlMask (WarlMask)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .active_i    (active_q),
    .busy_i      (busy_o),
    .pending_i   (pending_q),
    .reg_ack_o   (reg_ack_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_err_o   (reg_err_o),
    .shadow_o    (shadow),
    .lock_o      (lock),
    .commit_o    (commit)
  );

  assign last_pad = idx_q == IdxW'(NP - 1);

  // The scan reads the live shadow bank, so shadow writes that land before
  // the scan reaches a pad are picked up by the running sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    active_d  = active_q;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end

      ST_SCAN: begin
        if (commit) begin
          pending_d = 1'b1;
        end
        if (shadow[idx_q] != active_q[idx_q]) begin
          // Only one pad changes per cycle; the settle window follows it.
          active_d[idx_q] = shadow[idx_q];
          cnt_d           = SETTLE_LOAD;
          state_d         = ST_SETTLE;
        end else if (last_pad) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      ST_SETTLE: begin
        if (commit) begin
          pending_d = 1'b1;
        end
        if (cnt_q <= 8'd1) begin
          if (last_pad) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        // A COMMIT landing on the DONE cycle counts as pending and is
        // consumed immediately by the rerun from pad 0.
        idx_d     = '0;
        pending_d = 1'b0;
        state_d   = (pending_q || commit) ? ST_SCAN : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      active_q  <= {NP{ATTR_RESET[AttrDw-1:0]}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // MIO pads occupy the low indices, DIO pads follow.
  assign mio_attr_o = active_q[NMioPads-1:0];
  assign dio_attr_o = active_q[NP-1:NMioPads];
  assign busy_o     = state_q != ST_IDLE;
  assign done_o     = state_q == ST_DONE;

  // lock only gates register writes inside the regs block; a running
  // sequence is deliberately unaffected by it.
  logic unused_lock;
  assign unused_lock = lock;

endmodule

// File: tb/tb_padctrl_staged.sv
// tb_padctrl_staged: self-checking bench for padctrl_staged with a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_padctrl_staged;

  localparam int NMIO   = 16;
  localparam int NDIO   = 4;
  localparam int NP     = NMIO + NDIO;
  localparam int AW     = 8;
  localparam int SETTLE = 4;
  localparam logic [7:0] MASK = 8'h3F;
  localparam int NEVER = 32'h7fff_ffff;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 reg_req_i = 1'b0;
  logic                 reg_we_i = 1'b0;
  logic [7:0]           reg_addr_i = 8'h0;
  logic [31:0]          reg_wdata_i = 32'h0;
  logic                 reg_ack_o;
  logic [31:0]          reg_rdata_o;
  logic                 reg_err_o;
  logic [NMIO*AW-1:0]   mio_attr_o;
  logic [NDIO*AW-1:0]   dio_attr_o;
  logic                 busy_o;
  logic                 done_o;

  padctrl_staged #(
    .NMioPads     (NMIO),
    .NDioPads     (NDIO),
    .AttrDw       (AW),
    .WarlMask     (MASK),
    .SettleCycles (SETTLE)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_ack_o   (reg_ack_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_err_o   (reg_err_o),
    .mio_attr_o  (mio_attr_o),
    .dio_attr_o  (dio_attr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a timeline of pad visits. Each visited pad costs one
  // cycle, plus SETTLE cycles when its shadow differs from its active value;
  // the done pulse occupies the cycle right after the last pad's cost.
  logic [7:0] m_shadow [NP];
  logic [7:0] m_active [NP];
  bit m_lock, m_pend, m_run;
  int m_ptr, m_visit, m_done_cyc;
  int cyc = 0;
  int done_seen = 0;
  int busy_seen = 0;

  task automatic m_reset();
    for (int p = 0; p < NP; p++) begin
      m_shadow[p] = 8'h0;
      m_active[p] = 8'h0;
    end
    m_lock = 0; m_pend = 0; m_run = 0;
    m_ptr = 0; m_visit = NEVER; m_done_cyc = NEVER;
  endtask

  task automatic m_start(input int t);
    m_run = 1; m_ptr = 0; m_visit = t; m_done_cyc = NEVER;
  endtask

  function automatic bit m_mapped(input int a);
    return (a < NP) || (a >= 128 && a < 128 + NP) || a == 64 || a == 65 || a == 66;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < NP) return {24'd0, m_shadow[a]};
    if (a >= 128 && a < 128 + NP) return {24'd0, m_active[a-128]};
    if (a == 65) return {29'd0, m_pend, m_lock, m_run};
    return 32'd0;
  endfunction

  // One clock cycle: drive, advance model, clock, compare every output.
  task automatic cycle(input bit req, input bit we, input logic [7:0] addr, input logic [31:0] wd);
    bit commit, e_ack, e_err;
    logic [31:0] e_rd;
    logic [127:0] e_mio;
    logic [31:0] e_dio;
    int ai;
    ai = int'(addr);
    reg_req_i = req; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wd;

    commit = req && we && ai == 64 && wd[0] && !m_lock;
    e_ack  = req;
    e_err  = req && !m_mapped(ai);
    e_rd   = (req && !we) ? m_read(ai) : 32'd0;

    if (m_run && cyc == m_done_cyc) begin
      if (m_pend || commit) begin
        m_pend = 0;
        m_start(cyc + 1);
      end else begin
        m_run = 0;
        m_done_cyc = NEVER;
      end
    end else if (m_run) begin
      if (commit) m_pend = 1;
      if (m_ptr < NP && cyc == m_visit) begin
        if (m_shadow[m_ptr] != m_active[m_ptr]) begin
          m_active[m_ptr] = m_shadow[m_ptr];
          m_visit = cyc + 1 + SETTLE;
        end else begin
          m_visit = cyc + 1;
        end
        m_ptr++;
        if (m_ptr == NP) m_done_cyc = m_visit;
      end
    end else if (commit) begin
      m_start(cyc + 1);
    end

    if (req && we && !m_lock) begin
      if (ai < NP) m_shadow[ai] = wd[7:0] & MASK;
      if (ai == 66 && wd[0]) m_lock = 1;
    end

    @(posedge clk_i);
    #1;
    cyc++;
    reg_req_i = 0; reg_we_i = 0; reg_addr_i = 8'h0; reg_wdata_i = 32'h0;

    e_mio = '0;
    for (int p = 0; p < NMIO; p++) e_mio[p*AW +: AW] = m_active[p];
    for (int p = 0; p < NDIO; p++) e_dio[p*AW +: AW] = m_active[NMIO+p];

    chk("ack", {127'd0, reg_ack_o}, {127'd0, e_ack});
    if (e_ack) begin
      chk("err", {127'd0, reg_err_o}, {127'd0, e_err});
      if (!we) chk("rdata", {96'd0, reg_rdata_o}, {96'd0, e_rd});
    end
    chk("busy", {127'd0, busy_o}, {127'd0, m_run});
    chk("done", {127'd0, done_o}, {127'd0, (m_run && m_done_cyc == cyc)});
    chk("mio", mio_attr_o, e_mio);
    chk("dio", {96'd0, dio_attr_o}, {96'd0, e_dio});
    if (done_o) done_seen++;
    if (busy_o) busy_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h0, 32'h0);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400 && busy_o; i++) cycle(0, 0, 8'h0, 32'h0);
    chk(nm, {127'd0, busy_o}, 128'd0);
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic do_reset();
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_busy",  {127'd0, busy_o}, 128'd0);
    chk("rst_done",  {127'd0, done_o}, 128'd0);
    chk("rst_ack",   {127'd0, reg_ack_o}, 128'd0);
    chk("rst_err",   {127'd0, reg_err_o}, 128'd0);
    chk("rst_rdata", {96'd0, reg_rdata_o}, 128'd0);
    chk("rst_mio",   mio_attr_o, 128'd0);
    chk("rst_dio",   {96'd0, dio_attr_o}, 128'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_reset();
    done_seen = 0;
    busy_seen = 0;
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    bit          e_err;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[17];
    int cc, t2, t19, td, tb;
    bit found;

    // Register-map vectors, applied in order from reset.
    tbl[0]  = '{1, 8'h03, 32'h0000_00FF, 32'h00, 0};
    tbl[1]  = '{0, 8'h03, 32'h0,         32'h3F, 0};
    tbl[2]  = '{0, 8'h83, 32'h0,         32'h00, 0};
    tbl[3]  = '{0, 8'h50, 32'h0,         32'h00, 1};
    tbl[4]  = '{1, 8'h50, 32'h0000_00FF, 32'h00, 1};
    tbl[5]  = '{0, 8'h41, 32'h0,         32'h00, 0};
    tbl[6]  = '{1, 8'h13, 32'h0000_01AB, 32'h00, 0};
    tbl[7]  = '{0, 8'h13, 32'h0,         32'h2B, 0};
    tbl[8]  = '{0, 8'h14, 32'h0,         32'h00, 1};
    tbl[9]  = '{0, 8'h94, 32'h0,         32'h00, 1};
    tbl[10] = '{0, 8'h3F, 32'h0,         32'h00, 1};
    tbl[11] = '{1, 8'h80, 32'h0000_0012, 32'h00, 0};
    tbl[12] = '{0, 8'h80, 32'h0,         32'h00, 0};
    tbl[13] = '{0, 8'h40, 32'h0,         32'h00, 0};
    tbl[14] = '{1, 8'h42, 32'h0000_0000, 32'h00, 0};
    tbl[15] = '{0, 8'h41, 32'h0,         32'h00, 0};
    tbl[16] = '{0, 8'h03, 32'h0,         32'h3F, 0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, tbl[i].we, tbl[i].addr, tbl[i].wd);
      chk($sformatf("tbl%0d_err", i), {127'd0, reg_err_o}, {127'd0, tbl[i].e_err});
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), {96'd0, reg_rdata_o}, {96'd0, tbl[i].e_rd});
    end

    // Two changed pads: p2 changes 4 cycles after the COMMIT cycle, p19
    // another 4 settle + 17 scan cycles later; DONE after p19's settle.
    do_reset();
    cycle(1, 1, 8'h02, 32'h05);
    cycle(1, 1, 8'h13, 32'h07);
    cycle(1, 1, 8'h40, 32'h01);
    cc = cyc - 1;
    chk("039_busy_first", {127'd0, busy_o}, 128'd1);
    t2 = -1; t19 = -1; td = -1; tb = -1;
    for (int i = 0; i < 100 && tb < 0; i++) begin
      cycle(0, 0, 8'h0, 32'h0);
      if (t2 < 0 && mio_attr_o[2*AW +: AW] == 8'h05) t2 = cyc;
      if (t19 < 0 && dio_attr_o[3*AW +: AW] == 8'h07) t19 = cyc;
      if (done_o) td = cyc;
      if (!busy_o) tb = cyc;
    end
    chk("039_p2_time",   128'(t2 - cc), 128'd4);
    chk("039_p19_time",  128'(t19 - t2), 128'd21);
    chk("039_done_time", 128'(td - cc), 128'd29);
    chk("039_done_count", 128'(done_seen), 128'd1);
    chk("039_busy_fall", 128'(tb - td), 128'd1);

    // Two COMMITs while busy merge into a single rerun.
    do_reset();
    cycle(1, 1, 8'h00, 32'h01);
    cycle(1, 1, 8'h40, 32'h01);
    idle(2);
    cycle(1, 1, 8'h40, 32'h01);
    cycle(1, 1, 8'h40, 32'h01);
    cycle(1, 0, 8'h41, 32'h0);
    chk("040_status", {96'd0, reg_rdata_o}, 128'h5);
    wait_idle("040_idle_timeout");
    idle(5);
    chk("040_done_count", 128'(done_seen), 128'd2);

    // Locked: shadow write and COMMIT are dropped.
    do_reset();
    cycle(1, 1, 8'h42, 32'h01);
    cycle(1, 1, 8'h00, 32'h11);
    cycle(1, 1, 8'h40, 32'h01);
    idle(5);
    chk("041_busy_never", 128'(busy_seen), 128'd0);
    cycle(1, 0, 8'h00, 32'h0);
    chk("041_shadow", {96'd0, reg_rdata_o}, 128'h0);
    cycle(1, 0, 8'h41, 32'h0);
    chk("041_status", {96'd0, reg_rdata_o}, 128'h2);
    chk("041_mio", mio_attr_o, 128'h0);

    // Reset in the middle of a settle window aborts with no done pulse.
    do_reset();
    cycle(1, 1, 8'h05, 32'h01);
    cycle(1, 1, 8'h40, 32'h01);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle(0, 0, 8'h0, 32'h0);
      if (mio_attr_o[5*AW +: AW] == 8'h01) found = 1;
    end
    chk("042_reach_settle", {127'd0, found}, 128'd1);
    chk("042_busy_before", {127'd0, busy_o}, 128'd1);
    do_reset();
    idle(10);
    chk("042_no_done", 128'(done_seen), 128'd0);
    cycle(1, 0, 8'h05, 32'h0);
    chk("042_shadow_cleared", {96'd0, reg_rdata_o}, 128'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r, k;
      logic [7:0] a;
      logic [31:0] w;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        cycle(0, 0, 8'h0, 32'h0);
      end else if (r < 62) begin
        a = (r < 55) ? 8'($urandom_range(0, NP-1)) : 8'($urandom_range(0, 255));
        w = $urandom;
        if (a == 8'h42) w[0] = 1'b0;
        cycle(1, 1, a, w);
      end else if (r < 72) begin
        cycle(1, 1, 8'h40, 32'($urandom_range(0, 3)));
      end else begin
        k = $urandom_range(0, 3);
        case (k)
          0:       a = 8'($urandom_range(0, 255));
          1:       a = 8'($urandom_range(0, NP-1));
          2:       a = 8'(128 + $urandom_range(0, NP-1));
          default: a = 8'h41;
        endcase
        cycle(1, 0, a, 32'h0);
      end
    end
    wait_idle("rand_idle_timeout");
    cycle(1, 1, 8'h42, 32'h01);
    cycle(1, 1, 8'h07, 32'h2A);
    cycle(1, 1, 8'h40, 32'h01);
    idle(5);
    cycle(1, 0, 8'h41, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
